configurador_campos: RTL and testbench

CONFIGURADOR_CAMPOS -- requirements
Module: configurador_campos

---
 rtl/configurador_campos_pkg.sv | 82 ++++++++
 rtl/configurador_campos_if.sv | 15 +
 rtl/configurador_campos_bcd_paso.sv | 32 +++
 rtl/configurador_campos.sv | 203 ++++++++++++++++++++
 tb/tb_configurador_campos.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/configurador_campos_pkg.sv
// -----------------------------------------------------------------------------
// configurador_campos_pkg
// Shared definitions for the clock/date/timer field configurator:
//   - FSM state encoding (IDLE / EDIT / WRITE)
//   - cursor and field-storage index constants
//   - per-field packed-BCD min/max limits and a lookup helper
//   - reset value helper for the field storage
// -----------------------------------------------------------------------------
package configurador_campos_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EDIT  = 2'd1,
      ST_WRITE = 2'd2
   } estado_t;

   // Cursor positions inside a group
   localparam logic [2:0] IDX_HORA = 3'd0;
   localparam logic [2:0] IDX_MIN  = 3'd1;
   localparam logic [2:0] IDX_SEG  = 3'd2;
   localparam logic [2:0] IDX_DIA  = 3'd3;
   localparam logic [2:0] IDX_MES  = 3'd4;
   localparam logic [2:0] IDX_ANIO = 3'd5;

   localparam logic [2:0] CUR_MAX_RELOJ = 3'd5;
   localparam logic [2:0] CUR_MAX_TEMP  = 3'd2;

   // Flat storage slots: clock group 0..5, timer group 6..8
   localparam int NUM_CAMPOS   = 9;
   localparam int CAMPO_C_HORA = 0;
   localparam int CAMPO_C_DIA  = 3;
   localparam int CAMPO_C_MES  = 4;
   localparam int CAMPO_T_BASE = 6;

   // Packed-BCD limits
   localparam logic [7:0] HORA24_MIN = 8'h00;
   localparam logic [7:0] HORA24_MAX = 8'h23;
   localparam logic [7:0] HORA12_MIN = 8'h01;
   localparam logic [7:0] HORA12_MAX = 8'h12;
   localparam logic [7:0] MINSEG_MIN = 8'h00;
   localparam logic [7:0] MINSEG_MAX = 8'h59;
   localparam logic [7:0] DIA_MIN    = 8'h01;
   localparam logic [7:0] DIA_MAX    = 8'h31;
   localparam logic [7:0] MES_MIN    = 8'h01;
   localparam logic [7:0] MES_MAX    = 8'h12;
   localparam logic [7:0] ANIO_MIN   = 8'h00;
   localparam logic [7:0] ANIO_MAX   = 8'h99;

   typedef struct packed {
      logic [7:0] lo;
      logic [7:0] hi;
   } limite_t;

   // Wrap limits of the field under the cursor. Only the clock hour
   // depends on the 12/24-hour format; the timer hour is always 00..23.
   function automatic limite_t limites_campo(input logic       grupo,
                                             input logic [2:0] idx,
                                             input logic       doce);
      limite_t l;
      l = '{lo: MINSEG_MIN, hi: MINSEG_MAX};
      case (idx)
         IDX_HORA: begin
            if (doce && !grupo) l = '{lo: HORA12_MIN, hi: HORA12_MAX};
            else                l = '{lo: HORA24_MIN, hi: HORA24_MAX};
         end
         IDX_MIN:  l = '{lo: MINSEG_MIN, hi: MINSEG_MAX};
         IDX_SEG:  l = '{lo: MINSEG_MIN, hi: MINSEG_MAX};
         IDX_DIA:  l = '{lo: DIA_MIN,    hi: DIA_MAX};
         IDX_MES:  l = '{lo: MES_MIN,    hi: MES_MAX};
         IDX_ANIO: l = '{lo: ANIO_MIN,   hi: ANIO_MAX};
         default:  l = '{lo: MINSEG_MIN, hi: MINSEG_MAX};
      endcase
      return l;
   endfunction

   // Day and month start at 01, everything else at 00
   function automatic logic [7:0] valor_reset(input int idx);
      if ((idx == CAMPO_C_DIA) || (idx == CAMPO_C_MES)) return 8'h01;
      else                                               return 8'h00;
   endfunction

endpackage

// File: rtl/configurador_campos_if.sv
// -----------------------------------------------------------------------------
// configurador_campos_if
// Write handshake towards the downstream RTC writer.
//   wr_req : request, held until wr_ack          (configurator -> writer)
//   wr_grp : group being written, 0=clock 1=timer (configurator -> writer)
//   wr_ack : writer accepted the request          (writer -> configurator)
// -----------------------------------------------------------------------------
interface configurador_campos_if;
   logic wr_req;
   logic wr_grp;
   logic wr_ack;

   modport master (output wr_req, output wr_grp, input wr_ack);
   modport slave  (input wr_req, input wr_grp, output wr_ack);
endinterface

// File: rtl/configurador_campos_bcd_paso.sv
// -----------------------------------------------------------------------------
// bcd_paso
// Combinational one-step up/down counter on a packed-BCD byte with wrap.
//   valor_i : current value (assumed inside [min_i, max_i])
//   subir_i : 1 = increment, 0 = decrement
//   min_i   : lowest legal value (wrap target when going up past max_i)
//   max_i   : highest legal value (wrap target when going down past min_i)
//   valor_o : stepped value
// -----------------------------------------------------------------------------
module bcd_paso (
   input  logic [7:0] valor_i,
   input  logic       subir_i,
   input  logic [7:0] min_i,
   input  logic [7:0] max_i,
   output logic [7:0] valor_o
);

   // Step with decimal carry/borrow between the two nibbles
   always_comb begin
      valor_o = valor_i;
      if (subir_i) begin
         if (valor_i == max_i)             valor_o = min_i;
         else if (valor_i[3:0] == 4'd9)    valor_o = {valor_i[7:4] + 4'd1, 4'd0};
         else                              valor_o = {valor_i[7:4], valor_i[3:0] + 4'd1};
      end else begin
         if (valor_i == min_i)             valor_o = max_i;
         else if (valor_i[3:0] == 4'd0)    valor_o = {valor_i[7:4] - 4'd1, 4'd9};
         else                              valor_o = {valor_i[7:4], valor_i[3:0] - 4'd1};
      end
   end

endmodule

// File: rtl/configurador_campos.sv
// -----------------------------------------------------------------------------
// configurador_campos
// User-editable clock/date and timer fields with an RTC write handshake.
//   clk, btn_reset              : clock, asynchronous active-high reset
//   dism, aument, derec, izqda  : single-cycle strobes (dec, inc, right, left)
//   sw_conf                     : edit mode enable
//   sw_CT                       : group select, 0 = clock/date, 1 = timer
//   DOCE_24                     : 1 = 12-hour clock, 0 = 24-hour
//   escrib                      : write request level (rising edge starts write)
//   rtc (master)                : wr_req / wr_grp out, wr_ack in
//   c_hora..c_anio, t_hora..t_seg : packed-BCD fields
//   pm, cursor, editando        : AM/PM flag, selected field, EDIT indicator
// -----------------------------------------------------------------------------
module configurador_campos
   import configurador_campos_pkg::*;
(
   input  logic                        clk,
   input  logic                        btn_reset,
   input  logic                        dism,
   input  logic                        aument,
   input  logic                        derec,
   input  logic                        izqda,
   input  logic                        sw_conf,
   input  logic                        sw_CT,
   input  logic                        DOCE_24,
   input  logic                        escrib,
   configurador_campos_if.master       rtc,
   output logic [7:0]                  c_hora,
   output logic [7:0]                  c_min,
   output logic [7:0]                  c_seg,
   output logic [7:0]                  c_dia,
   output logic [7:0]                  c_mes,
   output logic [7:0]                  c_anio,
   output logic [7:0]                  t_hora,
   output logic [7:0]                  t_min,
   output logic [7:0]                  t_seg,
   output logic                        pm,
   output logic [2:0]                  cursor,
   output logic                        editando
);

   estado_t    estado_q, estado_d;
   logic       wr_grp_q, wr_grp_d;
   logic       escrib_q, doce_q, ct_q;
   logic [2:0] cursor_q, cursor_d;
   logic       pm_q, pm_d;
   logic [7:0] campo_q [NUM_CAMPOS];
   logic [7:0] campo_d [NUM_CAMPOS];

   logic       escrib_sube_s;
   logic       doce_cambio_s;
   logic       ct_cambio_s;
   logic       en_edicion_s;
   logic       paso_en_s;
   logic       mover_en_s;
   logic       toggle_pm_s;
   logic [2:0] cursor_max_s;
   logic [3:0] sel_idx_s;
   logic [7:0] campo_sel_s;
   logic [7:0] paso_s;
   logic [7:0] doce_hora_s;
   limite_t    lim_s;

   assign escrib_sube_s = escrib & ~escrib_q;
   assign doce_cambio_s = DOCE_24 ^ doce_q;
   assign ct_cambio_s   = sw_CT ^ ct_q;

   // A group change only re-homes the cursor; strobes in that cycle are dropped
   // so a stale cursor can never address the wrong group.
   assign en_edicion_s  = (estado_q == ST_EDIT) && !ct_cambio_s;
   assign paso_en_s     = en_edicion_s && (aument || dism);
   assign mover_en_s    = en_edicion_s && !aument && !dism;
   assign cursor_max_s  = sw_CT ? CUR_MAX_TEMP : CUR_MAX_RELOJ;
   assign sel_idx_s     = sw_CT ? (4'd6 + {1'b0, cursor_q}) : {1'b0, cursor_q};
   assign lim_s         = limites_campo(sw_CT, cursor_q, DOCE_24);
   assign doce_hora_s   = DOCE_24 ? HORA12_MAX : HORA24_MIN;

   // 11->12 going up or 12->11 going down crosses noon/midnight in 12-hour mode
   assign toggle_pm_s   = paso_en_s && !sw_CT && (cursor_q == IDX_HORA) && DOCE_24 &&
                          ((aument && (campo_sel_s == 8'h11)) ||
                           (!aument && (campo_sel_s == HORA12_MAX)));

   // Mux the field under the cursor
   always_comb begin
      campo_sel_s = 8'h00;
      for (int i = 0; i < NUM_CAMPOS; i++) begin
         campo_sel_s = (sel_idx_s == 4'(i)) ? campo_q[i] : campo_sel_s;
      end
   end

   bcd_paso u_bcd_paso (
      .valor_i (campo_sel_s),
      .subir_i (aument),
      .min_i   (lim_s.lo),
      .max_i   (lim_s.hi),
      .valor_o (paso_s)
   );

   // FSM next state and write-group latch
   always_comb begin
      estado_d = estado_q;
      wr_grp_d = wr_grp_q;
      case (estado_q)
         ST_IDLE: begin
            if (sw_conf) estado_d = ST_EDIT;
            else         estado_d = ST_IDLE;
         end
         ST_EDIT: begin
            if (!sw_conf) begin
               estado_d = ST_IDLE;
            end else if (escrib_sube_s) begin
               estado_d = ST_WRITE;
               wr_grp_d = sw_CT;
            end else begin
               estado_d = ST_EDIT;
            end
         end
         ST_WRITE: begin
            if (rtc.wr_ack) estado_d = sw_conf ? ST_EDIT : ST_IDLE;
            else            estado_d = ST_WRITE;
         end
         default: estado_d = ST_IDLE;
      endcase
   end

   // Field, cursor and pm next values; a format change overrides any hour step
   always_comb begin
      cursor_d = cursor_q;
      pm_d     = pm_q;
      for (int i = 0; i < NUM_CAMPOS; i++) begin
         campo_d[i] = campo_q[i];
         if (doce_cambio_s && (i == CAMPO_C_HORA))        campo_d[i] = doce_hora_s;
         else if (paso_en_s && (sel_idx_s == 4'(i)))      campo_d[i] = paso_s;
         else                                             campo_d[i] = campo_q[i];
      end

      if (ct_cambio_s)                         cursor_d = 3'd0;
      else if (mover_en_s && derec)            cursor_d = (cursor_q >= cursor_max_s) ? 3'd0 : cursor_q + 3'd1;
      else if (mover_en_s && izqda)            cursor_d = (cursor_q == 3'd0) ? cursor_max_s : cursor_q - 3'd1;
      else                                     cursor_d = cursor_q;

      if (doce_cambio_s || !DOCE_24)           pm_d = 1'b0;
      else if (toggle_pm_s)                    pm_d = ~pm_q;
      else                                     pm_d = pm_q;
   end

   // State and write-group registers
   always_ff @(posedge clk or posedge btn_reset) begin
      if (btn_reset) begin
         estado_q <= ST_IDLE;
         wr_grp_q <= 1'b0;
      end else begin
         estado_q <= estado_d;
         wr_grp_q <= wr_grp_d;
      end
   end

   // History copies for escrib edge and DOCE_24 / sw_CT change detection
   always_ff @(posedge clk or posedge btn_reset) begin
      if (btn_reset) begin
         escrib_q <= 1'b0;
         doce_q   <= 1'b0;
         ct_q     <= 1'b0;
      end else begin
         escrib_q <= escrib;
         doce_q   <= DOCE_24;
         ct_q     <= sw_CT;
      end
   end

   // Field storage, cursor and pm registers
   always_ff @(posedge clk or posedge btn_reset) begin
      if (btn_reset) begin
         for (int i = 0; i < NUM_CAMPOS; i++) begin
            campo_q[i] <= valor_reset(i);
         end
         cursor_q <= 3'd0;
         pm_q     <= 1'b0;
      end else begin
         campo_q  <= campo_d;
         cursor_q <= cursor_d;
         pm_q     <= pm_d;
      end
   end

   assign rtc.wr_req = (estado_q == ST_WRITE);
   assign rtc.wr_grp = wr_grp_q;
   assign editando   = (estado_q == ST_EDIT);
   assign cursor     = cursor_q;
   // Gated so pm reads 0 immediately whenever 24-hour format is selected
   assign pm         = pm_q & DOCE_24;

   assign c_hora = campo_q[0];
   assign c_min  = campo_q[1];
   assign c_seg  = campo_q[2];
   assign c_dia  = campo_q[3];
   assign c_mes  = campo_q[4];
   assign c_anio = campo_q[5];
   assign t_hora = campo_q[CAMPO_T_BASE];
   assign t_min  = campo_q[CAMPO_T_BASE + 1];
   assign t_seg  = campo_q[CAMPO_T_BASE + 2];

endmodule

// File: tb/tb_configurador_campos.sv
// -----------------------------------------------------------------------------
// tb_configurador_campos
// Scoreboard bench: the stimulus process steps an integer-valued reference
// model and queues the expected outputs; a monitor pops and compares them one
// time unit after every rising edge.
// -----------------------------------------------------------------------------
module tb_configurador_campos;

   logic clk = 1'b0;
   logic btn_reset = 1'b1;
   logic dism = 1'b0, aument = 1'b0, derec = 1'b0, izqda = 1'b0;
   logic sw_conf = 1'b0, sw_CT = 1'b0, DOCE_24 = 1'b0, escrib = 1'b0;
   logic [7:0] c_hora, c_min, c_seg, c_dia, c_mes, c_anio, t_hora, t_min, t_seg;
   logic pm, editando;
   logic [2:0] cursor;

   configurador_campos_if bus ();

   configurador_campos dut (
      .clk(clk), .btn_reset(btn_reset),
      .dism(dism), .aument(aument), .derec(derec), .izqda(izqda),
      .sw_conf(sw_conf), .sw_CT(sw_CT), .DOCE_24(DOCE_24), .escrib(escrib),
      .rtc(bus),
      .c_hora(c_hora), .c_min(c_min), .c_seg(c_seg), .c_dia(c_dia),
      .c_mes(c_mes), .c_anio(c_anio), .t_hora(t_hora), .t_min(t_min),
      .t_seg(t_seg), .pm(pm), .cursor(cursor), .editando(editando)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [8:0][7:0] f;
      logic            pm;
      logic [2:0]      cur;
      logic            req;
      logic            grp;
      logic            edit;
   } snap_t;

   snap_t exp_q[$];
   int    n_vec = 0;
   int    n_err = 0;
   bit    mon_on = 1'b0;

   // Shadow levels, copied onto the DUT inputs at the falling edge
   bit v_conf = 1'b0, v_ct = 1'b0, v_doce = 1'b0, v_esc = 1'b0, v_ack = 1'b0;

   // Reference model: plain decimal values, mode 0=idle 1=edit 2=write
   int m_f[9];
   int m_mode, m_cur;
   bit m_pm, m_grp, h_esc, h_doce, h_ct;

   task automatic chk(input string nm, input int act, input int exp_v);
      n_vec++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   function automatic logic [7:0] bcd(input int v);
      return 8'(((v / 10) * 16) + (v % 10));
   endfunction

   function automatic void lims(input bit ct, input int idx, input bit doce,
                                output int lo, output int hi);
      if (idx == 0)      begin lo = (doce && !ct) ? 1 : 0; hi = (doce && !ct) ? 12 : 23; end
      else if (idx <= 2) begin lo = 0; hi = 59; end
      else if (idx == 3) begin lo = 1; hi = 31; end
      else if (idx == 4) begin lo = 1; hi = 12; end
      else               begin lo = 0; hi = 99; end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 9; i++) m_f[i] = (i == 3 || i == 4) ? 1 : 0;
      m_mode = 0; m_cur = 0; m_pm = 0; m_grp = 0;
      h_esc = 0; h_doce = 0; h_ct = 0;
   endfunction

   function automatic void model_edge();
      bit rise, ct_chg, doce_chg;
      int maxc, idx, lo, hi, old;
      rise     = escrib && !h_esc;
      ct_chg   = (sw_CT != h_ct);
      doce_chg = (DOCE_24 != h_doce);
      maxc     = sw_CT ? 2 : 5;
      if (m_mode == 1 && !ct_chg) begin
         if (aument || dism) begin
            idx = sw_CT ? 6 + m_cur : m_cur;
            lims(sw_CT, m_cur, DOCE_24, lo, hi);
            old = m_f[idx];
            if (aument) m_f[idx] = (old == hi) ? lo : old + 1;
            else        m_f[idx] = (old == lo) ? hi : old - 1;
            if (!sw_CT && m_cur == 0 && DOCE_24 &&
                ((aument && old == 11) || (!aument && old == 12))) m_pm = !m_pm;
         end else if (derec) m_cur = (m_cur == maxc) ? 0 : m_cur + 1;
         else if (izqda)     m_cur = (m_cur == 0) ? maxc : m_cur - 1;
      end
      if (ct_chg) m_cur = 0;
      if (doce_chg) begin m_f[0] = DOCE_24 ? 12 : 0; m_pm = 0; end
      if (!DOCE_24) m_pm = 0;
      case (m_mode)
         0: if (sw_conf) m_mode = 1;
         1: if (!sw_conf) m_mode = 0;
            else if (rise) begin m_mode = 2; m_grp = sw_CT; end
         default: if (bus.wr_ack) m_mode = sw_conf ? 1 : 0;
      endcase
      h_esc = escrib; h_doce = DOCE_24; h_ct = sw_CT;
   endfunction

   function automatic snap_t expect_now();
      snap_t e;
      for (int i = 0; i < 9; i++) e.f[i] = bcd(m_f[i]);
      e.pm   = m_pm && DOCE_24;
      e.cur  = 3'(m_cur);
      e.req  = (m_mode == 2);
      e.grp  = m_grp;
      e.edit = (m_mode == 1);
      return e;
   endfunction

   task automatic apply_levels();
      sw_conf = v_conf; sw_CT = v_ct; DOCE_24 = v_doce; escrib = v_esc; bus.wr_ack = v_ack;
   endtask

   // One clock: strb = {aument, dism, derec, izqda}
   task automatic cyc(input logic [3:0] strb);
      @(negedge clk);
      btn_reset = 1'b0;
      apply_levels();
      {aument, dism, derec, izqda} = strb;
      model_edge();
      exp_q.push_back(expect_now());
   endtask

   // Reset asserted mid-cycle; wr_req and fields must drop without a clock edge
   task automatic do_reset();
      @(negedge clk);
      apply_levels();
      {aument, dism, derec, izqda} = 4'b0000;
      btn_reset = 1'b1;
      #1;
      chk("async_wr_req", bus.wr_req, 0);
      chk("async_c_min", c_min, 8'h00);
      chk("async_c_dia", c_dia, 8'h01);
      model_reset();
      mon_on = 1'b1;
      exp_q.push_back(expect_now());
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   // Monitor: compare every registered output against the queued expectation
   initial begin : monitor
      snap_t e;
      logic [8:0][7:0] obs;
      string nm [9] = '{"c_hora", "c_min", "c_seg", "c_dia", "c_mes", "c_anio",
                        "t_hora", "t_min", "t_seg"};
      forever begin
         @(posedge clk);
         #1;
         if (mon_on) begin
            if (exp_q.size() == 0) begin
               chk("scoreboard_empty", 1, 0);
            end else begin
               e   = exp_q.pop_front();
               obs = {t_seg, t_min, t_hora, c_anio, c_mes, c_dia, c_seg, c_min, c_hora};
               for (int i = 0; i < 9; i++) chk(nm[i], obs[i], e.f[i]);
               chk("pm", pm, e.pm);
               chk("cursor", cursor, e.cur);
               chk("wr_req", bus.wr_req, e.req);
               chk("wr_grp", bus.wr_grp, e.grp);
               chk("editando", editando, e.edit);
            end
         end
      end
   end

   initial begin : stimulus
      bus.wr_ack = 1'b0;
      model_reset();
      do_reset();

      // Minute wrap 59 -> 00
      v_conf = 1; cyc(4'b0000);
      cyc(4'b0010);
      cyc(4'b0100); after_edge(); chk("min_down_wrap", c_min, 8'h59);
      cyc(4'b1000); after_edge(); chk("min_up_wrap", c_min, 8'h00);
      chk("min_wrap_hora", c_hora, 8'h00); chk("min_wrap_cursor", cursor, 1);

      // 12-hour format and pm toggling
      v_doce = 1; cyc(4'b0000); after_edge(); chk("h12_entry", c_hora, 8'h12); chk("h12_pm", pm, 0);
      cyc(4'b0001);
      cyc(4'b1000); after_edge(); chk("h12_wrap", c_hora, 8'h01); chk("h12_wrap_pm", pm, 0);
      repeat (10) cyc(4'b1000);
      after_edge(); chk("h12_eleven", c_hora, 8'h11);
      cyc(4'b1000); after_edge(); chk("h12_noon", c_hora, 8'h12); chk("h12_noon_pm", pm, 1);
      cyc(4'b0100);
      v_doce = 0; cyc(4'b1000); after_edge(); chk("h24_override", c_hora, 8'h00); chk("h24_pm", pm, 0);

      // Timer group cursor wrap
      v_ct = 1; cyc(4'b0000);
      cyc(4'b0001); after_edge(); chk("tcur_left_wrap", cursor, 2);
      cyc(4'b0010); after_edge(); chk("tcur_right_wrap", cursor, 0);
      cyc(4'b0001);
      v_ct = 0; cyc(4'b0000); after_edge(); chk("ct_change_cursor", cursor, 0);

      // Write handshake on the timer group
      v_ct = 1; cyc(4'b0000);
      v_esc = 1; cyc(4'b0000); after_edge(); chk("wr_req_set", bus.wr_req, 1); chk("wr_grp_set", bus.wr_grp, 1);
      cyc(4'b1000); after_edge(); chk("write_ignores", t_hora, 8'h00);
      v_ack = 1; cyc(4'b0000); after_edge(); chk("wr_req_clr", bus.wr_req, 0); chk("back_edit", editando, 1);
      v_ack = 0; v_esc = 0; cyc(4'b0000);

      // Simultaneous strobes, then reset during a write
      cyc(4'b1010); after_edge(); chk("prio_field", t_hora, 8'h01); chk("prio_cursor", cursor, 0);
      v_esc = 1; cyc(4'b0000); after_edge(); chk("wr_req_again", bus.wr_req, 1);
      do_reset();
      v_esc = 0; cyc(4'b0000);

      // Randomized run
      for (int k = 0; k < 2500; k++) begin
         logic [3:0] s;
         bit chg;
         chg = 0;
         if ($urandom_range(0, 24) == 0) begin v_ct = !v_ct; chg = 1; end
         if ($urandom_range(0, 39) == 0) begin v_doce = !v_doce; chg = 1; end
         if ($urandom_range(0, 15) == 0) v_conf = !v_conf;
         if (!v_conf && $urandom_range(0, 3) == 0) v_conf = 1;
         if ($urandom_range(0, 3) == 0) v_esc = !v_esc;
         v_ack = ($urandom_range(0, 3) == 0);
         s = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         if (chg) s = 4'b0000;
         if ($urandom_range(0, 599) == 0) do_reset();
         else cyc(s);
      end

      @(posedge clk);
      #3;
      if (exp_q.size() != 0) chk("scoreboard_leftover", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
